// File: rtl/dist_fifo16.sv
// dist_fifo16: 16-entry first-word-fall-through FIFO built on distributed RAM.
//
// Storage is one 16x1 dual-port RAM per data bit (RAM16X1D style): the write
// pointer drives the synchronous write address, the read pointer drives the
// asynchronous read address, so the head word appears on data_o with no
// added latency.
//
// Ports:
//   clock_i      single clock, rising edge
//   reset_i      synchronous active-high reset
//   write_i      write request, data_i enqueued when accepted
//   data_i       write data (WIDTH bits)
//   read_i       pop request, head word removed when accepted
//   data_o       head-of-queue word (valid while empty_o is low)
//   empty_o      registered, count == 0
//   full_o       registered, count == 16
//   count_o      registered occupancy 0..16
//   overflow_o   sticky, set by a rejected write
//   underflow_o  sticky, set by a rejected read
module dist_fifo16 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             write_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             read_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [4:0]       count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic wr_en;
    logic rd_en;

    // A write into a full FIFO is still accepted when a pop frees the head
    // slot in the same cycle. Reset masks the RAM write strobe.
    assign wr_en = write_i & (~full_q | read_i) & ~reset_i;
    assign rd_en = read_i & ~empty_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        if (write_i && !wr_en) begin
            overflow_d = 1'b1;
        end
        if (read_i && !rd_en) begin
            underflow_d = 1'b1;
        end

        // Flags track the next count so they change together with count_o.
        empty_d = (count_d == 5'd0);
        full_d  = (count_d == 5'(DEPTH));
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= 5'd0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // One 16x1 dual-port RAM per data bit; contents are never cleared.
    for (genvar b = 0; b < WIDTH; b++) begin : g_ram_bit
        logic [DEPTH-1:0] ram_bit;

        always_ff @(posedge clock_i) begin
            if (wr_en) begin
                ram_bit[wr_ptr_q] <= data_i[b];
            end
        end

        assign data_o[b] = ram_bit[rd_ptr_q];
    end

    assign empty_o     = empty_q;
    assign full_o      = full_q;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_dist_fifo16.sv
// Self-checking bench for dist_fifo16: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_dist_fifo16;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       write_i = 1'b0;
    logic [7:0] data_i  = 8'h00;
    logic       read_i  = 1'b0;
    logic [7:0] data_o;
    logic       empty_o;
    logic       full_o;
    logic [4:0] count_o;
    logic       overflow_o;
    logic       underflow_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    dist_fifo16 #(.WIDTH(8)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .write_i    (write_i),
        .data_i     (data_i),
        .read_i     (read_i),
        .data_o     (data_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .underflow_o(underflow_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, model update, and full comparison.
    task automatic step(input logic rst, input logic w, input logic [7:0] d, input logic r,
                        input string tag);
        bit wacc;
        bit racc;
        reset_i = rst;
        write_i = w;
        data_i  = d;
        read_i  = r;
        @(posedge clock_i);
        #1;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            wacc = w && ((mq.size() < 16) || r);
            racc = r && (mq.size() > 0);
            if (racc) void'(mq.pop_front());
            if (wacc) mq.push_back(d);
            if (w && !wacc) m_ovf = 1'b1;
            if (r && !racc) m_unf = 1'b1;
        end
        check({tag, ".count"}, 32'(count_o), 32'(mq.size()));
        check({tag, ".empty"}, 32'(empty_o), 32'(mq.size() == 0));
        check({tag, ".full"}, 32'(full_o), 32'(mq.size() == 16));
        check({tag, ".ovf"}, 32'(overflow_o), 32'(m_ovf));
        check({tag, ".unf"}, 32'(underflow_o), 32'(m_unf));
        if (mq.size() > 0) check({tag, ".data"}, 32'(data_o), 32'(mq[0]));
    endtask

    initial begin
        // Reset, including a write request that must be ignored
        step(1'b1, 1'b1, 8'h77, 1'b1, "reset");
        step(1'b1, 1'b0, 8'h00, 1'b0, "reset2");

        // Single write becomes visible immediately
        step(1'b0, 1'b1, 8'hA5, 1'b0, "wr_a5");
        check("a5.direct_data", 32'(data_o), 32'h0000_00A5);
        check("a5.direct_count", 32'(count_o), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1, "rd_a5");

        // Fill with 0x00..0x0F, overflow, drain in order
        step(1'b1, 1'b0, 8'h00, 1'b0, "reset3");
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0, "fill");
        check("fill.direct_full", 32'(full_o), 32'd1);
        step(1'b0, 1'b1, 8'hFF, 1'b0, "ovf_write");
        check("ovf.direct_flag", 32'(overflow_o), 32'd1);
        check("ovf.direct_count", 32'(count_o), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("drain.direct_data", 32'(data_o), 32'(i));
            step(1'b0, 1'b0, 8'h00, 1'b1, "drain");
        end
        check("drain.direct_empty", 32'(empty_o), 32'd1);

        // Full with simultaneous write and read
        step(1'b1, 1'b0, 8'h00, 1'b0, "reset4");
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, "fill2");
        step(1'b0, 1'b1, 8'h55, 1'b1, "full_wr_rd");
        check("fullwr.direct_data", 32'(data_o), 32'h11);
        check("fullwr.direct_full", 32'(full_o), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "drain2");

        // Empty with simultaneous write and read
        step(1'b0, 1'b1, 8'h3C, 1'b1, "empty_wr_rd");
        check("emptywr.direct_data", 32'(data_o), 32'h3C);
        check("emptywr.direct_unf", 32'(underflow_o), 32'd1);

        // Occupancy held at 3 across 40 words, wrapping pointers
        step(1'b1, 1'b0, 8'h00, 1'b0, "reset5");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0, "prime");
        for (int i = 3; i < 40; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b1, "steady");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "flush");
        check("steady.direct_ovf", 32'(overflow_o), 32'd0);
        check("steady.direct_unf", 32'(underflow_o), 32'd0);

        // Reset mid-operation with 9 words queued and flags set
        step(1'b0, 1'b0, 8'h00, 1'b1, "unf_set");
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, "fill9");
        step(1'b1, 1'b1, 8'hEE, 1'b0, "mid_reset");
        check("midrst.direct_count", 32'(count_o), 32'd0);
        step(1'b0, 1'b1, 8'h5A, 1'b0, "post_reset_wr");
        check("postrst.direct_data", 32'(data_o), 32'h5A);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic rst;
            logic w;
            logic r;
            logic [7:0] d;
            rst = ($urandom_range(0, 99) == 0);
            w   = ($urandom_range(0, 99) < 55);
            r   = ($urandom_range(0, 99) < 45);
            d   = 8'($urandom_range(0, 255));
            step(rst, w, d, r, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dist_fifo16.md
DIST_FIFO16 -- requirements
Module: dist_fifo16

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH fixed at 16 (4-bit addressing), storage mapped onto RAM16X1D distributed RAM, one primitive per data bit.
REQ-003 clock_i  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 write_i  input  1  write request; data_i enqueued on the clock edge when accepted.
REQ-006 data_i  input  WIDTH  write data.
REQ-007 read_i  input  1  read/pop request; head word removed on the clock edge when accepted.
REQ-008 data_o  output  WIDTH  head-of-queue word (first-word fall-through), from the RAM's asynchronous DPO port.
REQ-009 empty_o  output  1  registered; high when count is 0.
REQ-010 full_o  output  1  registered; high when count is 16.
REQ-011 count_o  output  5  registered occupancy, 0 to 16.
REQ-012 overflow_o  output  1  sticky; set by a rejected write.
REQ-013 underflow_o  output  1  sticky; set by a rejected read.

Function
REQ-014 Write pointer SHALL drive RAM write address A[3:0]; read pointer SHALL drive DPRA[3:0]; RAM WE SHALL equal the accepted-write strobe.
REQ-015 Write accepted = write_i & (!full_o | read_i); read accepted = read_i & !empty_o.
REQ-016 Accepted write: RAM[wr_ptr] <= data_i, wr_ptr <= wr_ptr+1 modulo 16 (15 -> 0).
REQ-017 Accepted read: rd_ptr <= rd_ptr+1 modulo 16 (15 -> 0).
REQ-018 count_o: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-019 empty_o and full_o SHALL be updated in the same cycle as count_o, from the next count value; never both high.
REQ-020 data_o SHALL equal the oldest stored word whenever empty_o is low; value while empty_o is high is don't-care.
REQ-021 Latency: a word written at edge N SHALL be visible on data_o with empty_o low after edge N (zero added latency).
REQ-022 Write while full with read_i high: both SHALL be accepted; count stays 16, full_o stays high.
REQ-023 Write and read both requested while empty: write accepted, read rejected, count becomes 1, underflow_o set.
REQ-024 Write while full and read_i low: rejected, RAM, pointers and count unchanged, overflow_o set.
REQ-025 Read while empty and write_i low: rejected, state unchanged, underflow_o set.
REQ-026 overflow_o and underflow_o SHALL remain set until reset.
REQ-027 Ordering SHALL be strict FIFO across pointer wrap-around.

Reset
REQ-028 With reset_i high at a clock edge: wr_ptr=0, rd_ptr=0, count_o=0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0.
REQ-029 Reset SHALL take priority over simultaneous write_i/read_i; RAM write enable SHALL be forced low during reset.
REQ-030 RAM contents are not cleared; reset mid-operation discards all queued words.

Verification
REQ-031 Reset, then write 0xA5 one cycle -> after the edge: empty_o=0, count_o=1, data_o=0xA5.
REQ-032 Write 0x00..0x0F on 16 consecutive cycles -> full_o=1, count_o=16; a 17th write (0xFF) -> overflow_o=1, count_o=16; 16 reads return 0x00..0x0F in order, then empty_o=1.
REQ-033 With full, assert write_i=1 (0x55) and read_i=1 together -> count_o stays 16, data_o advances to the next word, 0x55 emerges 16th on drain.
REQ-034 Empty, read_i=1 with write_i=1 (0x3C) -> count_o=1, data_o=0x3C, underflow_o=1.
REQ-035 Push/pop 40 words with occupancy held at 3 -> pointers wrap at least twice, all words returned in order, no flag set.
REQ-036 Fill to 9 words, assert reset_i one cycle with write_i=1 -> count_o=0, empty_o=1, both sticky flags 0, next write reads back correctly.
